// File: rtl/weight_seq_pkg.sv
// Shared types and defaults for the Wixr weight-buffer index sequencer.
package weight_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   localparam int unsigned DEFAULT_BUF_LATENCY = 2;
   localparam int unsigned DEFAULT_DEPTH       = 42;

endpackage

// File: rtl/valid_delay_line.sv
// Delays the {issue, last_issue} flags by LATENCY cycles so they line up
// with the weight buffer's q_* outputs.
module valid_delay_line #(
   parameter int unsigned LATENCY = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic valid_i,
   input  logic last_i,
   output logic valid_o,
   output logic last_o
);

   logic [LATENCY-1:0] vld_q;
   logic [LATENCY-1:0] lst_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_q <= '0;
         lst_q <= '0;
      end else begin
         vld_q[0] <= valid_i;
         lst_q[0] <= last_i;
         for (int unsigned i = 1; i < LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            lst_q[i] <= lst_q[i-1];
         end
      end
   end

   assign valid_o = vld_q[LATENCY-1];
   assign last_o  = lst_q[LATENCY-1];

endmodule

// File: rtl/weight_index_sequencer.sv
// Sweeps the weight-buffer index 0..DEPTH-1 for num_passes passes with
// latency-aligned valid/last/done strobes. WEIGHT_SEQ_PERF_EN enables pause_cycles.
module weight_index_sequencer
   import weight_seq_pkg::*;
#(
   parameter int unsigned IDX_WIDTH   = 12,
   parameter int unsigned DEPTH       = DEFAULT_DEPTH,
   parameter int unsigned PASS_WIDTH  = 8,
   parameter int unsigned BUF_LATENCY = DEFAULT_BUF_LATENCY
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [PASS_WIDTH-1:0] num_passes,
   input  logic                  pause,
   output logic [IDX_WIDTH-1:0]  index,
   output logic                  q_valid,
   output logic                  q_last,
   output logic                  busy,
   output logic                  done,
   output logic [15:0]           pause_cycles
);

   localparam int unsigned DW = (BUF_LATENCY > 1) ? $clog2(BUF_LATENCY) : 1;
   localparam logic [IDX_WIDTH-1:0] IDX_LAST   = IDX_WIDTH'(DEPTH - 1);
   localparam logic [DW-1:0]        DRAIN_LAST = DW'(BUF_LATENCY - 1);

   state_e                state_q, state_d;
   logic [IDX_WIDTH-1:0]  idx_q, idx_d;
   logic [PASS_WIDTH-1:0] pass_q, pass_d;
   logic [PASS_WIDTH-1:0] passes_q, passes_d;
   logic [DW-1:0]         drain_q, drain_d;
   logic                  zero_done_q, zero_done_d;
   logic                  issue, final_issue;
   logic                  dl_last;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         pass_q      <= '0;
         passes_q    <= '0;
         drain_q     <= '0;
         zero_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         pass_q      <= pass_d;
         passes_q    <= passes_d;
         drain_q     <= drain_d;
         zero_done_q <= zero_done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      pass_d      = pass_q;
      passes_d    = passes_q;
      drain_d     = drain_q;
      zero_done_d = 1'b0;
      issue       = 1'b0;
      final_issue = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (num_passes != '0) begin
                  passes_d = num_passes;
                  idx_d    = '0;
                  pass_d   = '0;
                  state_d  = RUN;
               end else begin
                  zero_done_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (!pause) begin
               issue = 1'b1;
               if (idx_q == IDX_LAST) begin
                  idx_d  = '0;
                  pass_d = pass_q + PASS_WIDTH'(1);
                  if (pass_q == passes_q - PASS_WIDTH'(1)) begin
                     final_issue = 1'b1;
                     drain_d     = '0;
                     state_d     = DRAIN;
                  end
               end else begin
                  idx_d = idx_q + IDX_WIDTH'(1);
               end
            end
         end
         DRAIN: begin
            if (drain_q == DRAIN_LAST) begin
               state_d = IDLE;
            end else begin
               drain_d = drain_q + DW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   valid_delay_line #(
      .LATENCY (BUF_LATENCY)
   ) u_valid_delay_line (
      .clk     (clk),
      .reset_n (reset_n),
      .valid_i (issue),
      .last_i  (final_issue),
      .valid_o (q_valid),
      .last_o  (dl_last)
   );

   assign index  = idx_q;
   assign q_last = dl_last;
   assign busy   = (state_q != IDLE);
   // Zero-pass sweeps never enter RUN, so their done comes from a separate flop.
   assign done   = dl_last | zero_done_q;

`ifdef WEIGHT_SEQ_PERF_EN
   logic [15:0] pause_cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pause_cnt_q <= '0;
      end else if (state_q == IDLE && start) begin
         pause_cnt_q <= '0;
      end else if (state_q == RUN && pause && pause_cnt_q != '1) begin
         pause_cnt_q <= pause_cnt_q + 16'd1;
      end
   end

   assign pause_cycles = pause_cnt_q;
`else
   assign pause_cycles = '0;
`endif

endmodule
